// File: rtl/conv_window_gen_pkg.sv
// Shared types and elaboration-time helpers for the convolution window generator.
package conv_window_gen_pkg;

  localparam int unsigned DefW = 64;
  localparam int unsigned DefF = 3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned out_size(input int unsigned n, input int unsigned f,
                                           input int unsigned s);
    return (n - f) / s + 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of storage, addressed by column; the read returns the previous row's pixel
// at that column while the current pixel overwrites it on the same edge.
module conv_window_gen_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = DefW,
  parameter int unsigned AW = clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, FxF stride-S windows out (no padding), one registered output slot.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned F = DefF,
  parameter int unsigned S = 1,
  parameter int unsigned W = DefW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                start,
  input  logic [W-1:0]        pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [F*F*W-1:0]    win_data,
  output logic [clog2(N)-1:0] win_row,
  output logic [clog2(N)-1:0] win_col,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CW = clog2(N);
  localparam logic [CW-1:0] LastIdx  = CW'(N - 1);
  localparam logic [CW-1:0] FirstWin = CW'(F - 1);
  localparam logic [CW-1:0] PhLast   = CW'(S - 1);

  state_t state_q, state_d;
  logic [CW-1:0] col_q, row_q, col_ph_q, row_ph_q, ecol_q, erow_q;
  logic last_seen_q;
  logic accept, emit, is_last, row_hit, col_hit, frame_end;

  logic [W-1:0] lb_rd [F-1];
  logic [W-1:0] lb_wr [F-1];
  logic [W-1:0] col_in [F];
  logic [W-1:0] win_q [F][F];
  logic [W-1:0] win_nxt [F][F];
  logic [F*F*W-1:0] win_flat;

  // After the last pixel is taken no more are accepted until the next start.
  assign pix_ready  = en && (state_q == StRun) && !last_seen_q && (!win_valid || win_ready);
  assign accept     = pix_valid && pix_ready;
  assign row_hit    = (row_q >= FirstWin) && (row_ph_q == '0);
  assign col_hit    = (col_q >= FirstWin) && (col_ph_q == '0);
  assign emit       = accept && row_hit && col_hit;
  assign is_last    = (row_q == LastIdx) && (col_q == LastIdx);
  assign frame_end  = (accept && is_last && !emit) || (last_seen_q && win_valid && win_ready);
  assign busy       = (state_q == StRun);
  assign frame_done = (state_q == StDone);

  // Line buffers cascade: buffer k holds row (row-1-k) at each column.
  for (genvar k = 0; k < F - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = pix_in;
    end else begin : g_tail
      assign lb_wr[k] = lb_rd[k-1];
    end
    conv_window_gen_line_buffer #(
      .N (N),
      .W (W),
      .AW(CW)
    ) u_lb (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .wdata(lb_wr[k]),
      .rdata(lb_rd[k])
    );
  end

  for (genvar r = 0; r < F; r++) begin : g_row
    if (r == F - 1) begin : g_new
      assign col_in[r] = pix_in;
    end else begin : g_old
      assign col_in[r] = lb_rd[F-2-r];
    end
    for (genvar c = 0; c < F; c++) begin : g_col
      if (c == F - 1) begin : g_in
        assign win_nxt[r][c] = col_in[r];
      end else begin : g_sh
        assign win_nxt[r][c] = win_q[r][c+1];
      end
      assign win_flat[(r*F+c)*W +: W] = win_nxt[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) win_q <= win_nxt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (frame_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Stride phases count from the first window-aligned row/column, avoiding any divider.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      ecol_q      <= '0;
      erow_q      <= '0;
      last_seen_q <= 1'b0;
    end else if (state_q == StIdle && start && en) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      ecol_q      <= '0;
      erow_q      <= '0;
      last_seen_q <= 1'b0;
    end else if (accept) begin
      if (col_q == LastIdx) begin
        col_q    <= '0;
        row_q    <= row_q + CW'(1);
        col_ph_q <= '0;
        ecol_q   <= '0;
        if (row_q >= FirstWin) row_ph_q <= (row_ph_q == PhLast) ? '0 : row_ph_q + CW'(1);
        else                   row_ph_q <= '0;
        if (row_hit) erow_q <= erow_q + CW'(1);
      end else begin
        col_q <= col_q + CW'(1);
        if (col_q >= FirstWin) col_ph_q <= (col_ph_q == PhLast) ? '0 : col_ph_q + CW'(1);
        else                   col_ph_q <= '0;
        if (emit) ecol_q <= ecol_q + CW'(1);
      end
      if (is_last && emit) last_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (!en || state_q != StRun) begin
      win_valid <= 1'b0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_data  <= win_flat;
      win_row   <= erow_q;
      win_col   <= ecol_q;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule
